// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: FSM states, load funct3 codes
// and the load misalignment rule.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } wb_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Unsupported encodings behave as LW, so they need word alignment.
  function automatic logic ld_misaligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic m;
    case (f3)
      F3_LB, F3_LBU: m = 1'b0;
      F3_LH, F3_LHU: m = off[0];
      default:       m = (off != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks byte/halfword from a read word by offset
// and sign/zero-extends. Ports: word_i, off_i, funct3_i -> val_o.
module load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word_i,
  input  logic [1:0]      off_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] val_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word_i[7:0];
    unique case (off_i)
      2'd0: b = word_i[7:0];
      2'd1: b = word_i[15:8];
      2'd2: b = word_i[23:16];
      2'd3: b = word_i[31:24];
      default: b = word_i[7:0];
    endcase
    h = off_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_LB:   val_o = {{(XLEN-8){b[7]}}, b};
      F3_LBU:  val_o = {{(XLEN-8){1'b0}}, b};
      F3_LH:   val_o = {{(XLEN-16){h[15]}}, h};
      F3_LHU:  val_o = {{(XLEN-16){1'b0}}, h};
      default: val_o = word_i;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: retires ALU results or runs a data-memory load, then
// drives the register file write port. Ports: in_* handshake from
// execute, mem_* load port, write_* regfile port, load_misaligned pulse.
// Optional macro WB_INSTRET_EN adds a 64-bit instret counter output.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_result,
  input  logic            in_reg_write,
  input  logic            in_is_load,
  input  logic [2:0]      in_funct3,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [4:0]      write_reg,
  output logic [XLEN-1:0] write_data,
  output logic            reg_write_enable,
  output logic            load_misaligned
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]     instret
`endif
);

  wb_state_e state_q, state_d;

  logic [4:0]      rd_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [XLEN-1:0] addr_q;
  logic [4:0]      wreg_q;
  logic [XLEN-1:0] wdata_q;
  logic            we_q;
  logic            mis_q;
  logic [XLEN-1:0] ld_val;

  logic accept;
  logic mis;
  logic ld_done;

  assign accept  = in_valid && in_ready;
  assign mis     = ld_misaligned(in_funct3, in_result[1:0]);
  assign ld_done = (state_q == WAIT) && mem_rvalid;

  load_align #(.XLEN(XLEN)) u_align (
    .word_i   (mem_rdata),
    .off_i    (off_q),
    .funct3_i (f3_q),
    .val_o    (ld_val)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept && in_is_load && !mis) state_d = REQ;
      REQ:  if (mem_gnt) state_d = WAIT;
      WAIT: if (mem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    mem_req  = 1'b0;
    unique case (state_q)
      IDLE: in_ready = 1'b1;
      REQ:  mem_req  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q    <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      addr_q  <= '0;
      wreg_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      we_q  <= 1'b0;
      mis_q <= 1'b0;
      if (accept) begin
        if (!in_is_load) begin
          wreg_q  <= in_rd;
          wdata_q <= in_result;
          we_q    <= in_reg_write && (in_rd != 5'd0);
        end else if (mis) begin
          mis_q <= 1'b1;
        end else begin
          rd_q   <= in_rd;
          f3_q   <= in_funct3;
          off_q  <= in_result[1:0];
          addr_q <= {in_result[XLEN-1:2], 2'b00};
        end
      end
      if (ld_done) begin
        wreg_q  <= rd_q;
        wdata_q <= ld_val;
        we_q    <= (rd_q != 5'd0);
      end
    end
  end

  assign mem_addr         = addr_q;
  assign write_reg        = wreg_q;
  assign write_data       = wdata_q;
  assign reg_write_enable = we_q;
  assign load_misaligned  = mis_q;

`ifdef WB_INSTRET_EN
  // nw_q marks a completion that produced neither strobe nor pulse,
  // aligned to the same cycle a strobe would have appeared.
  logic        nw_q;
  logic [63:0] instret_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nw_q      <= 1'b0;
      instret_q <= '0;
    end else begin
      nw_q <= (accept && !in_is_load &&
               !(in_reg_write && (in_rd != 5'd0))) ||
              (ld_done && (rd_q == 5'd0));
      if (we_q || mis_q || nw_q) instret_q <= instret_q + 64'd1;
    end
  end

  assign instret = instret_q;
`endif

endmodule
